// File: rtl/io_controlador.sv
// CPU I/O responder: stalls on IN until a debounced key press, freezes on HALT,
// and converts OUT words to active-low 7-segment digits with a serial shift-add-3.
module io_controlador #(
  parameter int unsigned DATA_WIDTH      = 28,
  parameter int unsigned DIGITS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  OpIn,
  input  logic                  OpOut,
  input  logic                  OpHalt,
  input  logic [DATA_WIDTH-1:0] dado_saida,
  input  logic [17:0]           switches,
  input  logic                  botao,
  output logic                  cpu_enable,
  output logic [17:0]           switches_in,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  halted,
  output logic                  ocupado
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  typedef enum logic [2:0] {OCIOSO, ESPERA, LIBERA, GUARDA, HALT} estado_t;
  estado_t estado;

  logic             bot_s1, bot_s2, bot_deb;
  logic [CNT_W-1:0] bot_cnt;
  logic [17:0]      sw_s1, sw_s2;
  logic             press;
  logic             accept, start;

  // Press fires in the same cycle the debounced level commits to 0.
  assign press  = bot_deb && !bot_s2 && (bot_cnt == CNT_MAX);
  assign accept = cpu_enable && (estado == OCIOSO);
  assign start  = accept && OpOut && !OpIn && !OpHalt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      bot_s1  <= 1'b1;
      bot_s2  <= 1'b1;
      bot_deb <= 1'b1;
      bot_cnt <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
    end else begin
      bot_s1 <= botao;
      bot_s2 <= bot_s1;
      sw_s1  <= switches;
      sw_s2  <= sw_s1;
      if (bot_s2 == bot_deb) begin
        bot_cnt <= '0;
      end else if (bot_cnt == CNT_MAX) begin
        bot_cnt <= '0;
        bot_deb <= bot_s2;
      end else begin
        bot_cnt <= bot_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= OCIOSO;
      cpu_enable  <= 1'b0;
      halted      <= 1'b0;
      switches_in <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          cpu_enable <= 1'b1;
          if (cpu_enable && OpHalt) begin
            estado     <= HALT;
            cpu_enable <= 1'b0;
            halted     <= 1'b1;
          end else if (cpu_enable && OpIn) begin
            estado     <= ESPERA;
            cpu_enable <= 1'b0;
          end
        end
        ESPERA: begin
          if (press) begin
            switches_in <= sw_s2;
            estado      <= LIBERA;
            cpu_enable  <= 1'b1;
          end
        end
        LIBERA: begin
          estado     <= GUARDA;
          cpu_enable <= 1'b1;
        end
        GUARDA: begin
          estado     <= OCIOSO;
          cpu_enable <= 1'b1;
        end
        default: begin
          cpu_enable <= 1'b0;
          halted     <= 1'b1;
        end
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] shreg;
  logic [4*DIGITS-1:0]   bcd, bcd_adj;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  sat;
  logic [7*DIGITS-1:0]   hex_next;

  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  // Scan from the top digit; blanking stops at the first nonzero digit or at digit0.
  always_comb begin
    logic       seen;
    logic [3:0] d;
    int unsigned idx;
    hex_next = '1;
    seen     = 1'b0;
    d        = '0;
    idx      = 0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      idx = DIGITS - 1 - j;
      d   = sat ? 4'd9 : bcd[4*idx +: 4];
      if (d != 4'd0 || idx == 0) seen = 1'b1;
      hex_next[7*idx +: 7] = seen ? seg7(d) : 7'h7F;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      shreg   <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      sat     <= 1'b0;
      ocupado <= 1'b0;
      hex     <= {{(DIGITS-1){7'h7F}}, 7'h40};
    end else if (start) begin
      shreg   <= dado_saida;
      bcd     <= '0;
      bit_cnt <= '0;
      sat     <= (64'(dado_saida) >= LIMIT);
      ocupado <= 1'b1;
    end else if (ocupado) begin
      if (bit_cnt == BIT_LAST) begin
        hex     <= hex_next;
        ocupado <= 1'b0;
      end else begin
        bcd     <= {bcd_adj[4*DIGITS-2:0], shreg[DATA_WIDTH-1]};
        shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_controlador.sv
// Directed bench for io_controlador: IN handshake with debounce, OUT conversion,
// restart, saturation, blanking, HALT and reset recovery.
module tb_io_controlador;

  logic        clock = 1'b0;
  logic        reset;
  logic        OpIn, OpOut, OpHalt;
  logic [27:0] dado_saida;
  logic [17:0] switches;
  logic        botao;
  logic        cpu_enable;
  logic [17:0] switches_in;
  logic [55:0] hex;
  logic        halted;
  logic        ocupado;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S9 = 7'h10, BL = 7'h7F;

  io_controlador #(
    .DATA_WIDTH(28),
    .DIGITS(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .OpIn(OpIn),
    .OpOut(OpOut),
    .OpHalt(OpHalt),
    .dado_saida(dado_saida),
    .switches(switches),
    .botao(botao),
    .cpu_enable(cpu_enable),
    .switches_in(switches_in),
    .hex(hex),
    .halted(halted),
    .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  function automatic logic [55:0] hx(input logic [6:0] a7, a6, a5, a4, a3, a2, a1, a0);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_release(input string tag, input int exp_n);
    int n;
    n = 0;
    while (cpu_enable !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(exp_n));
  endtask

  task automatic do_out(input string tag, input logic [27:0] v,
                        input logic [55:0] prev, input logic [55:0] exp);
    dado_saida = v;
    OpOut = 1'b1;
    tick();
    OpOut = 1'b0;
    check({tag, "_busy"}, 64'(ocupado), 64'd1);
    check({tag, "_nostall"}, 64'(cpu_enable), 64'd1);
    repeat (28) begin
      tick();
      check({tag, "_hold"}, 64'(hex), 64'(prev));
    end
    tick();
    check({tag, "_hex"}, 64'(hex), 64'(exp));
    check({tag, "_done"}, 64'(ocupado), 64'd0);
  endtask

  logic [55:0] rst_hex, h1234, h_all9, h10203, h42;

  initial begin
    rst_hex = hx(BL, BL, BL, BL, BL, BL, BL, S0);
    h1234   = hx(BL, BL, BL, BL, S1, S2, S3, S4);
    h_all9  = hx(S9, S9, S9, S9, S9, S9, S9, S9);
    h10203  = hx(BL, BL, BL, S1, S0, S2, S0, S3);
    h42     = hx(BL, BL, BL, BL, BL, BL, S4, S2);

    reset = 1'b0; OpIn = 1'b0; OpOut = 1'b0; OpHalt = 1'b0;
    dado_saida = '0; switches = '0; botao = 1'b1;
    repeat (3) tick();
    check("rst_en", 64'(cpu_enable), 64'd0);
    check("rst_hex", 64'(hex), 64'(rst_hex));
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_busy", 64'(ocupado), 64'd0);
    check("rst_sw", 64'(switches_in), 64'd0);
    reset = 1'b1;
    tick();
    check("post_rst_en", 64'(cpu_enable), 64'd1);

    // IN with a clean press
    switches = 18'h2A5A5;
    OpIn = 1'b1;
    tick();
    OpIn = 1'b0;
    botao = 1'b0;
    check("in1_stall", 64'(cpu_enable), 64'd0);
    check("in1_sw_hold", 64'(switches_in), 64'd0);
    wait_release("in1_latency", 6);
    check("in1_sw", 64'(switches_in), 64'h2A5A5);
    OpIn = 1'b1;
    botao = 1'b1;
    tick();
    check("guarda_en", 64'(cpu_enable), 64'd1);
    tick();
    check("guarda_ignores_op", 64'(cpu_enable), 64'd1);
    tick();
    OpIn = 1'b0;
    check("in2_stall", 64'(cpu_enable), 64'd0);

    // IN with a bouncing key
    switches = 18'h15A5A;
    repeat (8) tick();
    check("in2_wait", 64'(cpu_enable), 64'd0);
    repeat (2) begin
      botao = 1'b0; repeat (2) tick();
      botao = 1'b1; repeat (2) tick();
    end
    repeat (6) tick();
    check("bounce_no_release", 64'(cpu_enable), 64'd0);
    check("bounce_sw_hold", 64'(switches_in), 64'h2A5A5);
    botao = 1'b0;
    wait_release("in2_latency", 6);
    check("in2_sw", 64'(switches_in), 64'h15A5A);
    botao = 1'b1;
    repeat (8) tick();
    check("in2_idle_en", 64'(cpu_enable), 64'd1);

    // OUT conversions
    do_out("out1234", 28'd1234, rst_hex, h1234);

    dado_saida = 28'd5;
    OpOut = 1'b1;
    tick();
    OpOut = 1'b0;
    repeat (9) begin
      tick();
      check("abort_hold_a", 64'(hex), 64'(h1234));
    end
    dado_saida = 28'd99999999;
    OpOut = 1'b1;
    tick();
    OpOut = 1'b0;
    repeat (28) begin
      tick();
      check("abort_hold_b", 64'(hex), 64'(h1234));
    end
    tick();
    check("abort_hex", 64'(hex), 64'(h_all9));
    check("abort_done", 64'(ocupado), 64'd0);

    do_out("out0", 28'd0, h_all9, rst_hex);
    do_out("out_1e8", 28'd100000000, rst_hex, h_all9);
    do_out("out10203", 28'd10203, h_all9, h10203);
    do_out("out_max", 28'hFFFFFFF, h10203, h_all9);

    // HALT beats IN, then everything is ignored until reset
    OpHalt = 1'b1;
    OpIn = 1'b1;
    tick();
    OpHalt = 1'b0;
    OpIn = 1'b0;
    check("halt_en", 64'(cpu_enable), 64'd0);
    check("halt_flag", 64'(halted), 64'd1);
    botao = 1'b0;
    OpOut = 1'b1;
    dado_saida = 28'd42;
    repeat (12) tick();
    OpOut = 1'b0;
    botao = 1'b1;
    check("halt_en_hold", 64'(cpu_enable), 64'd0);
    check("halt_flag_hold", 64'(halted), 64'd1);
    check("halt_no_out", 64'(hex), 64'(h_all9));
    check("halt_no_busy", 64'(ocupado), 64'd0);
    reset = 1'b0;
    tick();
    check("halt_rst_flag", 64'(halted), 64'd0);
    check("halt_rst_hex", 64'(hex), 64'(rst_hex));
    reset = 1'b1;
    tick();
    check("halt_rst_en", 64'(cpu_enable), 64'd1);
    do_out("out42", 28'd42, rst_hex, h42);

    // reset in the middle of a conversion leaves no trace
    dado_saida = 28'd777;
    OpOut = 1'b1;
    tick();
    OpOut = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    check("midrst_busy", 64'(ocupado), 64'd0);
    check("midrst_hex", 64'(hex), 64'(rst_hex));
    reset = 1'b1;
    repeat (35) tick();
    check("midrst_hex_after", 64'(hex), 64'(rst_hex));
    check("midrst_busy_after", 64'(ocupado), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
